// File: rtl/el2_pkg.sv
// Shared types for the LSU fault tracker: the precise error packet and the imprecise-error FSM states.
package el2_pkg;

  localparam int EL2_ERR_CNT_W = 16;

  typedef struct packed {
    logic        store;
    logic        misalign;
    logic [3:0]  mscause;
    logic [31:0] addr;
  } el2_lsu_err_pkt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    PEND_OVF = 2'd2
  } el2_imp_err_state_e;

endpackage

// File: rtl/el2_lsu_exc_tracker_if.sv
// LSU-fault / TLU-facing signal bundle for el2_lsu_exc_tracker.
// slave = tracker side, master = LSU/TLU driver side.
interface el2_lsu_exc_tracker_if #(
  parameter int CNT_W = 16
);
  logic              lsu_pkt_d_valid;
  logic              lsu_pkt_d_store;
  logic              lsu_pkt_d_dma;
  logic              access_fault_d;
  logic              misaligned_fault_d;
  logic [3:0]        exc_mscause_d;
  logic [31:0]       start_addr_d;
  logic              flush_r;
  logic              bus_err_valid;
  logic [31:0]       bus_err_addr;
  logic              bus_err_store;
  logic              tlu_imprecise_ack;
  logic              lsu_err_r_valid;
  logic              lsu_err_r_store;
  logic              lsu_err_r_misalign;
  logic [3:0]        lsu_err_r_mscause;
  logic [31:0]       lsu_err_r_addr;
  logic              imp_err_pending;
  logic              imp_err_store;
  logic [31:0]       imp_err_addr;
  logic              imp_err_overflow;
  logic [CNT_W-1:0]  precise_err_cnt;
  logic [CNT_W-1:0]  imprecise_err_cnt;

  modport slave (
    input  lsu_pkt_d_valid, lsu_pkt_d_store, lsu_pkt_d_dma, access_fault_d,
           misaligned_fault_d, exc_mscause_d, start_addr_d, flush_r,
           bus_err_valid, bus_err_addr, bus_err_store, tlu_imprecise_ack,
    output lsu_err_r_valid, lsu_err_r_store, lsu_err_r_misalign, lsu_err_r_mscause,
           lsu_err_r_addr, imp_err_pending, imp_err_store, imp_err_addr,
           imp_err_overflow, precise_err_cnt, imprecise_err_cnt
  );

  modport master (
    output lsu_pkt_d_valid, lsu_pkt_d_store, lsu_pkt_d_dma, access_fault_d,
           misaligned_fault_d, exc_mscause_d, start_addr_d, flush_r,
           bus_err_valid, bus_err_addr, bus_err_store, tlu_imprecise_ack,
    input  lsu_err_r_valid, lsu_err_r_store, lsu_err_r_misalign, lsu_err_r_mscause,
           lsu_err_r_addr, imp_err_pending, imp_err_store, imp_err_addr,
           imp_err_overflow, precise_err_cnt, imprecise_err_cnt
  );

endinterface

// File: rtl/el2_lsu_imprecise_err_latch.sv
// Holds the first unacknowledged imprecise bus error until the TLU acks it.
// Optional saturating error counter enabled by RV_LSU_ERR_STATS_EN.
module el2_lsu_imprecise_err_latch
  import el2_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_err_valid,
  input  logic [31:0]      bus_err_addr,
  input  logic             bus_err_store,
  input  logic             tlu_imprecise_ack,
  output logic             imp_err_pending,
  output logic             imp_err_store,
  output logic [31:0]      imp_err_addr,
  output logic             imp_err_overflow,
  output logic [CNT_W-1:0] imprecise_err_cnt
);

  el2_imp_err_state_e state_reg, state_next;
  logic [31:0]        addr_reg, addr_next;
  logic               store_reg, store_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
    end
  end

  // An ack paired with a new error retires the old one and latches the new one in the same cycle.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    case (state_reg)
      IDLE: begin
        if (bus_err_valid) begin
          state_next = PEND;
          addr_next  = bus_err_addr;
          store_next = bus_err_store;
        end
      end
      PEND, PEND_OVF: begin
        if (tlu_imprecise_ack) begin
          if (bus_err_valid) begin
            state_next = PEND;
            addr_next  = bus_err_addr;
            store_next = bus_err_store;
          end else begin
            state_next = IDLE;
          end
        end else if (bus_err_valid) begin
          state_next = PEND_OVF;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imp_err_pending  = (state_reg != IDLE);
  assign imp_err_overflow = (state_reg == PEND_OVF);
  assign imp_err_store    = store_reg;
  assign imp_err_addr     = addr_reg;

`ifdef RV_LSU_ERR_STATS_EN
  logic [CNT_W-1:0] imp_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      imp_cnt_reg <= '0;
    end else if (bus_err_valid && (imp_cnt_reg != {CNT_W{1'b1}})) begin
      imp_cnt_reg <= imp_cnt_reg + CNT_W'(1);
    end
  end

  assign imprecise_err_cnt = imp_cnt_reg;
`else
  assign imprecise_err_cnt = '0;
`endif

endmodule

// File: rtl/el2_lsu_exc_tracker.sv
// Pipelines LSU D-stage faults D->M->R into a precise TLU error packet and tracks imprecise bus errors.
// Optional saturating error counters enabled by RV_LSU_ERR_STATS_EN.
module el2_lsu_exc_tracker
  import el2_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  el2_lsu_exc_tracker_if.slave bus
);

  logic             valid_d;
  el2_lsu_err_pkt_t pkt_d;
  logic             valid_m_reg, valid_r_reg;
  el2_lsu_err_pkt_t pkt_m_reg, pkt_r_reg;

  assign valid_d = bus.lsu_pkt_d_valid & ~bus.lsu_pkt_d_dma &
                   (bus.access_fault_d | bus.misaligned_fault_d);

  // Misaligned wins when both faults are flagged.
  always_comb begin
    pkt_d          = '0;
    pkt_d.store    = bus.lsu_pkt_d_store;
    pkt_d.misalign = bus.misaligned_fault_d;
    pkt_d.mscause  = bus.exc_mscause_d;
    pkt_d.addr     = bus.start_addr_d;
  end

  // A flush kills whatever sits in M; a fault arriving in D during the flush still enters M.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m_reg <= 1'b0;
      valid_r_reg <= 1'b0;
      pkt_m_reg   <= '0;
      pkt_r_reg   <= '0;
    end else begin
      valid_m_reg <= valid_d;
      valid_r_reg <= valid_m_reg & ~bus.flush_r;
      if (valid_d) begin
        pkt_m_reg <= pkt_d;
      end
      if (valid_m_reg) begin
        pkt_r_reg <= pkt_m_reg;
      end
    end
  end

  assign bus.lsu_err_r_valid    = valid_r_reg;
  assign bus.lsu_err_r_store    = pkt_r_reg.store;
  assign bus.lsu_err_r_misalign = pkt_r_reg.misalign;
  assign bus.lsu_err_r_mscause  = pkt_r_reg.mscause;
  assign bus.lsu_err_r_addr     = pkt_r_reg.addr;

`ifdef RV_LSU_ERR_STATS_EN
  logic [CNT_W-1:0] precise_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      precise_cnt_reg <= '0;
    end else if (valid_r_reg && (precise_cnt_reg != {CNT_W{1'b1}})) begin
      precise_cnt_reg <= precise_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.precise_err_cnt = precise_cnt_reg;
`else
  assign bus.precise_err_cnt = '0;
`endif

  el2_lsu_imprecise_err_latch #(
    .CNT_W(CNT_W)
  ) u_imp_latch (
    .clk               (clk),
    .rst               (rst),
    .bus_err_valid     (bus.bus_err_valid),
    .bus_err_addr      (bus.bus_err_addr),
    .bus_err_store     (bus.bus_err_store),
    .tlu_imprecise_ack (bus.tlu_imprecise_ack),
    .imp_err_pending   (bus.imp_err_pending),
    .imp_err_store     (bus.imp_err_store),
    .imp_err_addr      (bus.imp_err_addr),
    .imp_err_overflow  (bus.imp_err_overflow),
    .imprecise_err_cnt (bus.imprecise_err_cnt)
  );

endmodule

// File: tb/tb_el2_lsu_exc_tracker.sv
// Self-checking bench for el2_lsu_exc_tracker: directed scenarios plus a randomized run against a behavioural model.
module tb_el2_lsu_exc_tracker;

  localparam int CNT_W = 16;
  localparam int NRAND = 400;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  el2_lsu_exc_tracker_if #(.CNT_W(CNT_W)) bus ();

  el2_lsu_exc_tracker #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lsu_pkt_d_valid    = 1'b0;
    bus.lsu_pkt_d_store    = 1'b0;
    bus.lsu_pkt_d_dma      = 1'b0;
    bus.access_fault_d     = 1'b0;
    bus.misaligned_fault_d = 1'b0;
    bus.exc_mscause_d      = 4'h0;
    bus.start_addr_d       = 32'h0;
    bus.flush_r            = 1'b0;
    bus.bus_err_valid      = 1'b0;
    bus.bus_err_addr       = 32'h0;
    bus.bus_err_store      = 1'b0;
    bus.tlu_imprecise_ack  = 1'b0;
  endtask

  task automatic set_d(input logic st, input logic dma, input logic af, input logic mf,
                       input logic [3:0] msc, input logic [31:0] addr);
    bus.lsu_pkt_d_valid    = 1'b1;
    bus.lsu_pkt_d_store    = st;
    bus.lsu_pkt_d_dma      = dma;
    bus.access_fault_d     = af;
    bus.misaligned_fault_d = mf;
    bus.exc_mscause_d      = msc;
    bus.start_addr_d       = addr;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [74:0] outs;
    do_reset();
    outs = {bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
            bus.lsu_err_r_mscause, bus.lsu_err_r_addr, bus.imp_err_pending,
            bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow};
    checks++;
    if (outs !== 75'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%0h exp=0", outs);
    end
    checks++;
    if ({bus.precise_err_cnt, bus.imprecise_err_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL reset_counters got=%0h/%0h exp=0/0", bus.precise_err_cnt, bus.imprecise_err_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_precise_load();
    set_d(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'hF004_0000);
    tick();
    idle_inputs();
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_early_valid got=%0b exp=0", bus.lsu_err_r_valid);
    end
    tick();
    checks++;
    if ({bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
         bus.lsu_err_r_mscause, bus.lsu_err_r_addr} !== {1'b1, 1'b0, 1'b0, 4'h2, 32'hF004_0000}) begin
      fails++;
      $display("FAIL load_pkt got v=%0b st=%0b mis=%0b msc=%0h addr=%08h exp v=1 st=0 mis=0 msc=2 addr=f0040000",
               bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
               bus.lsu_err_r_mscause, bus.lsu_err_r_addr);
    end
    tick();
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_one_cycle got=%0b exp=0", bus.lsu_err_r_valid);
    end
    $display("test_precise_load done");
  endtask

  task automatic test_precise_store_both();
    set_d(1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 32'h0000_1236);
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
         bus.lsu_err_r_mscause, bus.lsu_err_r_addr} !== {1'b1, 1'b1, 1'b1, 4'h1, 32'h0000_1236}) begin
      fails++;
      $display("FAIL store_both_pkt got v=%0b st=%0b mis=%0b msc=%0h addr=%08h exp v=1 st=1 mis=1 msc=1 addr=00001236",
               bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
               bus.lsu_err_r_mscause, bus.lsu_err_r_addr);
    end
    tick();
    $display("test_precise_store_both done");
  endtask

  task automatic test_kill();
    // DMA fault never reports
    set_d(1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h2000_0000);
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL dma_valid got=%0b exp=0", bus.lsu_err_r_valid);
    end
    // flush while the fault sits in M
    set_d(1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'h2000_0004);
    tick();
    idle_inputs();
    bus.flush_r = 1'b1;
    tick();
    bus.flush_r = 1'b0;
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_m_valid got=%0b exp=0", bus.lsu_err_r_valid);
    end
    // fault presented in the flush cycle itself survives
    set_d(1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'h2000_0008);
    bus.flush_r = 1'b1;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({bus.lsu_err_r_valid, bus.lsu_err_r_addr} !== {1'b1, 32'h2000_0008}) begin
      fails++;
      $display("FAIL flush_d_capture got v=%0b addr=%08h exp v=1 addr=20000008",
               bus.lsu_err_r_valid, bus.lsu_err_r_addr);
    end
    tick();
    $display("test_kill done");
  endtask

  task automatic test_back_to_back();
    set_d(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 32'hA000_0000);
    tick();
    set_d(1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 32'hB000_0004);
    tick();
    idle_inputs();
    checks++;
    if ({bus.lsu_err_r_valid, bus.lsu_err_r_addr, bus.lsu_err_r_mscause} !== {1'b1, 32'hA000_0000, 4'h2}) begin
      fails++;
      $display("FAIL b2b_first got v=%0b addr=%08h msc=%0h exp v=1 addr=a0000000 msc=2",
               bus.lsu_err_r_valid, bus.lsu_err_r_addr, bus.lsu_err_r_mscause);
    end
    tick();
    checks++;
    if ({bus.lsu_err_r_valid, bus.lsu_err_r_addr, bus.lsu_err_r_mscause,
         bus.lsu_err_r_store, bus.lsu_err_r_misalign} !== {1'b1, 32'hB000_0004, 4'h7, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_second got v=%0b addr=%08h msc=%0h exp v=1 addr=b0000004 msc=7",
               bus.lsu_err_r_valid, bus.lsu_err_r_addr, bus.lsu_err_r_mscause);
    end
    tick();
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_tail got=%0b exp=0", bus.lsu_err_r_valid);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_imprecise();
    do_reset();
    bus.bus_err_valid = 1'b1; bus.bus_err_addr = 32'h1000_0010; bus.bus_err_store = 1'b1;
    tick();
    bus.bus_err_addr = 32'h1000_0020; bus.bus_err_store = 1'b0;
    checks++;
    if ({bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow} !==
        {1'b1, 1'b1, 32'h1000_0010, 1'b0}) begin
      fails++;
      $display("FAIL imp_first got p=%0b st=%0b addr=%08h ovf=%0b exp p=1 st=1 addr=10000010 ovf=0",
               bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow);
    end
    tick();
    checks++;
    if ({bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow} !==
        {1'b1, 1'b1, 32'h1000_0010, 1'b1}) begin
      fails++;
      $display("FAIL imp_overflow got p=%0b st=%0b addr=%08h ovf=%0b exp p=1 st=1 addr=10000010 ovf=1",
               bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow);
    end
    bus.bus_err_addr = 32'h1000_0030; bus.bus_err_store = 1'b0; bus.tlu_imprecise_ack = 1'b1;
    tick();
    checks++;
    if ({bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow} !==
        {1'b1, 1'b0, 32'h1000_0030, 1'b0}) begin
      fails++;
      $display("FAIL imp_ack_new got p=%0b st=%0b addr=%08h ovf=%0b exp p=1 st=0 addr=10000030 ovf=0",
               bus.imp_err_pending, bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow);
    end
    bus.bus_err_valid = 1'b0;
    tick();
    checks++;
    if ({bus.imp_err_pending, bus.imp_err_overflow} !== 2'b00) begin
      fails++;
      $display("FAIL imp_ack_idle got p=%0b ovf=%0b exp p=0 ovf=0", bus.imp_err_pending, bus.imp_err_overflow);
    end
    tick();
    checks++;
    if (bus.imp_err_pending !== 1'b0) begin
      fails++;
      $display("FAIL imp_ack_in_idle got p=%0b exp p=0", bus.imp_err_pending);
    end
    idle_inputs();
    $display("test_imprecise done");
  endtask

  task automatic test_random();
    logic        qual_q[NRAND];
    logic [37:0] pkt_q[NRAND];
    logic        m_pend, m_ovf, m_st, exp_rv, fl, bev, ack, v, dma, af, mf, st;
    logic [31:0] m_addr;
    int          pcnt, icnt;
    logic [15:0] exp_pc, exp_ic;
    do_reset();
    m_pend = 1'b0; m_ovf = 1'b0; m_st = 1'b0; m_addr = 32'h0; pcnt = 0; icnt = 0;
    for (int c = 0; c < NRAND; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      dma = ($urandom_range(0, 5) == 0);
      af  = $urandom_range(0, 1) == 1;
      mf  = $urandom_range(0, 2) == 0;
      st  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 5) == 0);
      bev = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 3) == 0);
      set_d(st, dma, af, mf, 4'($urandom), $urandom);
      bus.lsu_pkt_d_valid   = v;
      bus.flush_r           = fl;
      bus.bus_err_valid     = bev;
      bus.bus_err_addr      = $urandom;
      bus.bus_err_store     = $urandom_range(0, 1) == 1;
      bus.tlu_imprecise_ack = ack;
      qual_q[c] = v && !dma && (af || mf);
      pkt_q[c]  = {st, mf, bus.exc_mscause_d, bus.start_addr_d};
      // model: the first unacked bus error is remembered; later ones only raise overflow
      if (m_pend && ack) begin
        m_pend = 1'b0;
        m_ovf  = 1'b0;
      end
      if (bev) begin
        if (!m_pend) begin
          m_pend = 1'b1; m_addr = bus.bus_err_addr; m_st = bus.bus_err_store;
        end else begin
          m_ovf = 1'b1;
        end
        icnt++;
      end
      exp_rv = (c > 0) && qual_q[(c > 0) ? c - 1 : 0] && !fl;
      tick();
      if (exp_rv) pcnt++;
      checks++;
      if (bus.lsu_err_r_valid !== exp_rv) begin
        fails++;
        $display("FAIL rand_r_valid cyc=%0d got=%0b exp=%0b", c, bus.lsu_err_r_valid, exp_rv);
      end else if (exp_rv) begin
        checks++;
        if ({bus.lsu_err_r_store, bus.lsu_err_r_misalign, bus.lsu_err_r_mscause, bus.lsu_err_r_addr} !== pkt_q[c-1]) begin
          fails++;
          $display("FAIL rand_r_pkt cyc=%0d got=%0h exp=%0h", c,
                   {bus.lsu_err_r_store, bus.lsu_err_r_misalign, bus.lsu_err_r_mscause, bus.lsu_err_r_addr}, pkt_q[c-1]);
        end
      end
      checks++;
      if ({bus.imp_err_pending, bus.imp_err_overflow} !== {m_pend, m_ovf}) begin
        fails++;
        $display("FAIL rand_imp_state cyc=%0d got p=%0b ovf=%0b exp p=%0b ovf=%0b", c,
                 bus.imp_err_pending, bus.imp_err_overflow, m_pend, m_ovf);
      end else if (m_pend) begin
        checks++;
        if ({bus.imp_err_store, bus.imp_err_addr} !== {m_st, m_addr}) begin
          fails++;
          $display("FAIL rand_imp_data cyc=%0d got st=%0b addr=%08h exp st=%0b addr=%08h", c,
                   bus.imp_err_store, bus.imp_err_addr, m_st, m_addr);
        end
      end
    end
`ifdef RV_LSU_ERR_STATS_EN
    exp_pc = 16'(pcnt);
    exp_ic = 16'(icnt);
`else
    exp_pc = 16'h0;
    exp_ic = 16'h0;
`endif
    checks++;
    if ({bus.precise_err_cnt, bus.imprecise_err_cnt} !== {exp_pc, exp_ic}) begin
      fails++;
      $display("FAIL rand_counters got=%0h/%0h exp=%0h/%0h", bus.precise_err_cnt, bus.imprecise_err_cnt, exp_pc, exp_ic);
    end
    idle_inputs();
    tick();
    tick();
    $display("test_random done, %0d cycles, %0d precise, %0d bus errors", NRAND, pcnt, icnt);
  endtask

  task automatic test_counters();
    logic [15:0] exp_c;
    do_reset();
`ifdef RV_LSU_ERR_STATS_EN
    force dut.precise_cnt_reg = 16'hFFFE;
    force dut.u_imp_latch.imp_cnt_reg = 16'hFFFE;
    #1;
    release dut.precise_cnt_reg;
    release dut.u_imp_latch.imp_cnt_reg;
    exp_c = 16'hFFFF;
`else
    exp_c = 16'h0;
`endif
    for (int i = 0; i < 3; i++) begin
      set_d(1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 32'h100 + 32'(i));
      bus.bus_err_valid = 1'b1;
      bus.bus_err_addr  = 32'h200 + 32'(i);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.precise_err_cnt !== exp_c) begin
      fails++;
      $display("FAIL cnt_precise got=%0h exp=%0h", bus.precise_err_cnt, exp_c);
    end
    checks++;
    if (bus.imprecise_err_cnt !== exp_c) begin
      fails++;
      $display("FAIL cnt_imprecise got=%0h exp=%0h", bus.imprecise_err_cnt, exp_c);
    end
    $display("test_counters done");
  endtask

  task automatic test_reset_mid_pending();
    logic [74:0] outs;
    bus.bus_err_valid = 1'b1; bus.bus_err_addr = 32'hDEAD_0000; bus.bus_err_store = 1'b1;
    tick();
    bus.bus_err_addr = 32'hDEAD_0004;
    set_d(1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 32'hCAFE_0000);
    tick();
    checks++;
    if ({bus.imp_err_pending, bus.imp_err_overflow} !== 2'b11) begin
      fails++;
      $display("FAIL rstmid_setup got p=%0b ovf=%0b exp p=1 ovf=1", bus.imp_err_pending, bus.imp_err_overflow);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outs = {bus.lsu_err_r_valid, bus.lsu_err_r_store, bus.lsu_err_r_misalign,
            bus.lsu_err_r_mscause, bus.lsu_err_r_addr, bus.imp_err_pending,
            bus.imp_err_store, bus.imp_err_addr, bus.imp_err_overflow};
    checks++;
    if (outs !== 75'h0 || bus.precise_err_cnt !== 16'h0 || bus.imprecise_err_cnt !== 16'h0) begin
      fails++;
      $display("FAIL rstmid_outputs got=%0h cnt=%0h/%0h exp=0", outs, bus.precise_err_cnt, bus.imprecise_err_cnt);
    end
    tick();
    checks++;
    if (bus.lsu_err_r_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pipe_flushed got=%0b exp=0", bus.lsu_err_r_valid);
    end
    $display("test_reset_mid_pending done");
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_precise_load();
    test_precise_store_both();
    test_kill();
    test_back_to_back();
    test_imprecise();
    test_random();
    test_counters();
    test_reset_mid_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
